// File: rtl/z16_instr_loader.sv
// z16_instr_loader
// Receives a byte stream (16-bit word count N, low byte first, then N words,
// each low byte first) and writes the words into instruction memory at
// consecutive even byte addresses. The CPU core is held in reset while a load
// is running or after a rejected load.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_start               begin a new load (honoured in IDLE, DONE, ERR)
//   i_byte, i_byte_valid  input byte stream, transfers when o_byte_ready=1
//   o_byte_ready          loader accepts a byte this cycle
//   o_we/o_waddr/o_wdata  one-cycle write strobe, byte address, data word
//   o_busy                load in progress
//   o_done                last load completed
//   o_error               last load rejected (N==0 or N>MEM_WORDS)
//   o_cpu_rst_n           active-low CPU hold, low while loading or in error
// All outputs are driven straight from flops.
module z16_instr_loader #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  output logic        o_byte_ready,
  output logic        o_we,
  output logic [15:0] o_waddr,
  output logic [15:0] o_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic        o_cpu_rst_n
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DAT_LO = 3'd3,
    DAT_HI = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  // Capacity widened to 17 bits so the length check cannot wrap.
  localparam logic [16:0] MEM_WORDS_W = 17'(MEM_WORDS);

  state_t      state_r, state_s;
  logic [7:0]  len_lo_r, len_lo_s;
  logic [15:0] len_r, len_s;
  logic [7:0]  dat_lo_r, dat_lo_s;
  logic [15:0] index_r, index_s;

  logic        byte_ready_r, byte_ready_s;
  logic        we_r, we_s;
  logic [15:0] waddr_r, waddr_s;
  logic [15:0] wdata_r, wdata_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        error_r, error_s;
  logic        cpu_rst_n_r, cpu_rst_n_s;

  logic        xfer_s;
  logic [15:0] len_word_s;
  logic [16:0] index_inc_s;

  // byte_ready_r mirrors the current state, so it qualifies the handshake.
  assign xfer_s      = i_byte_valid & byte_ready_r;
  assign len_word_s  = {i_byte, len_lo_r};
  assign index_inc_s = {1'b0, index_r} + 17'd1;

  // Next-state and datapath decode
  always_comb begin
    state_s  = state_r;
    len_lo_s = len_lo_r;
    len_s    = len_r;
    dat_lo_s = dat_lo_r;
    index_s  = index_r;
    we_s     = 1'b0;
    waddr_s  = waddr_r;
    wdata_s  = wdata_r;
    case (state_r)
      IDLE, DONE, ERR: begin
        if (i_start) begin
          state_s = LEN_LO;
          index_s = 16'd0;
        end else begin
          state_s = state_r;
        end
      end
      LEN_LO: begin
        if (xfer_s) begin
          len_lo_s = i_byte;
          state_s  = LEN_HI;
        end else begin
          state_s  = LEN_LO;
        end
      end
      LEN_HI: begin
        if (xfer_s) begin
          len_s = len_word_s;
          if ((len_word_s == 16'd0) || ({1'b0, len_word_s} > MEM_WORDS_W)) begin
            state_s = ERR;
          end else begin
            state_s = DAT_LO;
          end
        end else begin
          state_s = LEN_HI;
        end
      end
      DAT_LO: begin
        if (xfer_s) begin
          dat_lo_s = i_byte;
          state_s  = DAT_HI;
        end else begin
          state_s  = DAT_LO;
        end
      end
      DAT_HI: begin
        if (xfer_s) begin
          // Word is complete: strobe it next cycle at byte address 2*index.
          we_s    = 1'b1;
          waddr_s = {index_r[14:0], 1'b0};
          wdata_s = {i_byte, dat_lo_r};
          index_s = index_inc_s[15:0];
          if (index_inc_s < {1'b0, len_r}) begin
            state_s = DAT_LO;
          end else begin
            state_s = DONE;
          end
        end else begin
          state_s = DAT_HI;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Status outputs decoded from the next state so they land in flops
  // aligned with the state they describe.
  always_comb begin
    byte_ready_s = 1'b0;
    busy_s       = 1'b0;
    done_s       = 1'b0;
    error_s      = 1'b0;
    cpu_rst_n_s  = 1'b1;
    case (state_s)
      LEN_LO, LEN_HI, DAT_LO, DAT_HI: begin
        byte_ready_s = 1'b1;
        busy_s       = 1'b1;
        cpu_rst_n_s  = 1'b0;
      end
      DONE: begin
        done_s = 1'b1;
      end
      ERR: begin
        error_s     = 1'b1;
        cpu_rst_n_s = 1'b0;
      end
      default: begin
        cpu_rst_n_s = 1'b1;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r      <= IDLE;
      len_lo_r     <= 8'd0;
      len_r        <= 16'd0;
      dat_lo_r     <= 8'd0;
      index_r      <= 16'd0;
      byte_ready_r <= 1'b0;
      we_r         <= 1'b0;
      waddr_r      <= 16'd0;
      wdata_r      <= 16'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      cpu_rst_n_r  <= 1'b1;
    end else begin
      state_r      <= state_s;
      len_lo_r     <= len_lo_s;
      len_r        <= len_s;
      dat_lo_r     <= dat_lo_s;
      index_r      <= index_s;
      byte_ready_r <= byte_ready_s;
      we_r         <= we_s;
      waddr_r      <= waddr_s;
      wdata_r      <= wdata_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      error_r      <= error_s;
      cpu_rst_n_r  <= cpu_rst_n_s;
    end
  end

  assign o_byte_ready = byte_ready_r;
  assign o_we         = we_r;
  assign o_waddr      = waddr_r;
  assign o_wdata      = wdata_r;
  assign o_busy       = busy_r;
  assign o_done       = done_r;
  assign o_error      = error_r;
  assign o_cpu_rst_n  = cpu_rst_n_r;

endmodule

// File: doc/z16_instr_loader.md
Z16_INSTR_LOADER -- requirements
Module: z16_instr_loader

Interface
REQ-001 Parameter: MEM_WORDS, default 1024, is the capacity of the target instruction memory in 16-bit words.
REQ-002 Port: i_clk  in  1  single clock; all state changes on its rising edge.
REQ-003 Port: i_rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: i_start  in  1  begin a new load; sampled high for one cycle.
REQ-005 Port: i_byte  in  8  input stream byte.
REQ-006 Port: i_byte_valid  in  1  i_byte is valid this cycle.
REQ-007 Port: o_byte_ready  out  1  loader accepts a byte this cycle.
REQ-008 Port: o_we  out  1  instruction memory write strobe, one cycle per word.
REQ-009 Port: o_waddr  out  16  byte address of the write, always even.
REQ-010 Port: o_wdata  out  16  instruction word to write.
REQ-011 Port: o_busy  out  1  a load is in progress.
REQ-012 Port: o_done  out  1  last load completed successfully.
REQ-013 Port: o_error  out  1  last load rejected, due to a bad length.
REQ-014 Port: o_cpu_rst_n  out  1  active-low hold for the CPU core; low while loading or in error.

Function
REQ-015 Stream format: 2-byte word count N (low byte first), then N words, each sent low byte first.
REQ-016 A byte transfers only on a rising edge where i_byte_valid=1 and o_byte_ready=1; i_byte_valid may drop for any number of cycles without data loss.
REQ-017 The state machine SHALL use exactly these states: IDLE, LEN_LO, LEN_HI, DAT_LO, DAT_HI, DONE, ERR.
REQ-018 o_byte_ready=1 exactly in LEN_LO, LEN_HI, DAT_LO and DAT_HI; it is 0 in all other states.
REQ-019 i_start=1 in IDLE, DONE or ERR SHALL: go to LEN_LO, clear o_done and o_error, and clear the word index to 0.
REQ-020 i_start SHALL be ignored in LEN_LO, LEN_HI, DAT_LO and DAT_HI.
REQ-021 Transfers advance the state as follows: LEN_LO->LEN_HI; LEN_HI->DAT_LO, or ->ERR if N==0 or N>MEM_WORDS; DAT_LO->DAT_HI.
REQ-022 When the high byte is transferred in DAT_HI, the next cycle SHALL have o_we=1 for exactly one cycle, with o_wdata={hi,lo} and o_waddr=2*index.
REQ-023 The index increments by 1 after each write; index width is 16 bits, and index never exceeds N.
REQ-024 In DAT_HI, after a transfer: go to DAT_LO if index+1<N, else go to DONE; the final o_we and o_done=1 appear in the same cycle.
REQ-025 o_done remains 1 in DONE until the next i_start; o_error remains 1 in ERR until the next i_start.
REQ-026 o_busy=1 exactly in LEN_LO through DAT_HI.
REQ-027 o_cpu_rst_n=0 in LEN_LO through DAT_HI and in ERR; it is 1 in IDLE and DONE.
REQ-028 All outputs SHALL be registered; there is no combinational path from any input to any output.
REQ-029 No write occurs for N==0 or N>MEM_WORDS; N==MEM_WORDS is legal, with last o_waddr=2*(MEM_WORDS-1).
REQ-030 A byte transfer and the write strobe of the previous word may occur in the same cycle; no bubble is required between words.

Reset
REQ-031 Asserting i_rst_n low SHALL, at any time including mid-load, force IDLE immediately, with index=0.
REQ-032 Output values while in reset: o_byte_ready=0, o_we=0, o_waddr=0, o_wdata=0, o_busy=0, o_done=0, o_error=0, o_cpu_rst_n=1.
REQ-033 After a reset mid-load, no further o_we occurs until a new i_start; partially assembled bytes are discarded.

Verification
REQ-034 Start, then bytes 05 00 40 00 5D 60 00 00 00 00 6C 00 with valid held high -> writes (0x0000,0x0040), (0x0002,0x605D), (0x0004,0x0000), (0x0006,0x0000), (0x0008,0x006C); o_done=1 with the last o_we; o_cpu_rst_n returns to 1.
REQ-035 Same stream with random 0-3 cycle valid gaps -> identical writes; exactly 5 o_we pulses.
REQ-036 Length 00 00 -> ERR after the 2nd byte; o_error=1, o_cpu_rst_n=0, no o_we, o_byte_ready=0; a later i_start clears o_error.
REQ-037 With MEM_WORDS=4: length 04 00 -> last write at 0x0006 and o_done=1; length 05 00 -> ERR with no writes.
REQ-038 i_start pulsed during DAT_LO -> ignored, and the write sequence is unchanged.
REQ-039 i_rst_n low after 3 of 5 words -> all outputs take their reset values; a new start with 01 00 34 12 -> single write (0x0000,0x1234).
